// File: rtl/pad_thru_cfg_sequencer.sv
// Serial configuration sequencer for the openframe pad ring: streams one word per pad over thru0/thru1, then strobes load.
// Optional abort input is enabled by defining PAD_CFG_ABORT_EN.
module pad_thru_cfg_sequencer #(
    parameter int NUM_PADS = 44,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 4,
    localparam int AW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
`ifdef PAD_CFG_ABORT_EN
    input  logic                abort,
`endif
    output logic [AW-1:0]       cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_data,
    output logic                serial_data,
    output logic                serial_clock,
    output logic                serial_load,
    output logic                busy,
    output logic                done
);

    localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [AW-1:0] LAST_PAD = AW'(NUM_PADS - 1);
    localparam logic [BW-1:0] MSB_BIT  = BW'(CFG_BITS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [AW-1:0]       pad_reg, pad_next;
    logic [BW-1:0]       bit_reg, bit_next;
    logic [DW-1:0]       div_reg, div_next;
    logic [CFG_BITS-1:0] shift_reg, shift_next;

    logic                serial_data_reg, serial_data_next;
    logic                serial_clock_reg, serial_clock_next;
    logic                serial_load_reg, serial_load_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;

    logic [CFG_BITS-1:0] bit_sel_next;
    logic                phase_end;
    logic                abort_req;

    assign phase_end = (div_reg == DIV_LAST);

`ifdef PAD_CFG_ABORT_EN
    assign abort_req = abort && (state_reg != IDLE) && (state_reg != DONE);
`else
    assign abort_req = 1'b0;
`endif

    // One-hot select of the bit that will be on the wire next cycle; avoids
    // indexing past CFG_BITS when it is not a power of two.
    generate
        for (genvar gi = 0; gi < CFG_BITS; gi++) begin : g_bit_sel
            assign bit_sel_next[gi] = (bit_next == BW'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        pad_next   = pad_reg;
        bit_next   = bit_reg;
        div_next   = div_reg;
        shift_next = shift_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                    pad_next   = LAST_PAD;
                    div_next   = '0;
                end
            end
            FETCH: begin
                shift_next = cfg_data;
                bit_next   = MSB_BIT;
                div_next   = '0;
                state_next = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    div_next   = '0;
                    state_next = SHIFT_HI;
                end else begin
                    div_next = div_reg + DW'(1);
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    div_next = '0;
                    if (bit_reg != '0) begin
                        bit_next   = bit_reg - BW'(1);
                        state_next = SHIFT_LO;
                    end else if (pad_reg != '0) begin
                        pad_next   = pad_reg - AW'(1);
                        state_next = FETCH;
                    end else begin
                        state_next = LOAD;
                    end
                end else begin
                    div_next = div_reg + DW'(1);
                end
            end
            LOAD: begin
                if (phase_end) begin
                    div_next   = '0;
                    state_next = DONE;
                end else begin
                    div_next = div_reg + DW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (abort_req) begin
            state_next = IDLE;
            div_next   = '0;
        end
    end

    // Pad-facing outputs are decoded from the next state and registered so
    // thru0/thru1 and the load strobe leave the core glitch-free.
    always_comb begin
        serial_clock_next = (state_next == SHIFT_HI);
        serial_load_next  = (state_next == LOAD);
        done_next         = (state_next == DONE);
        busy_next         = (state_next == FETCH) || (state_next == SHIFT_LO) ||
                            (state_next == SHIFT_HI) || (state_next == LOAD);
        serial_data_next  = ((state_next == SHIFT_LO) || (state_next == SHIFT_HI)) &&
                            (|(shift_next & bit_sel_next));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= IDLE;
            pad_reg          <= '0;
            bit_reg          <= '0;
            div_reg          <= '0;
            shift_reg        <= '0;
            serial_data_reg  <= 1'b0;
            serial_clock_reg <= 1'b0;
            serial_load_reg  <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            pad_reg          <= pad_next;
            bit_reg          <= bit_next;
            div_reg          <= div_next;
            shift_reg        <= shift_next;
            serial_data_reg  <= serial_data_next;
            serial_clock_reg <= serial_clock_next;
            serial_load_reg  <= serial_load_next;
            busy_reg         <= busy_next;
            done_reg         <= done_next;
        end
    end

    // pad_reg only moves on entry to FETCH, so it doubles as the held address.
    assign cfg_addr     = pad_reg;
    assign serial_data  = serial_data_reg;
    assign serial_clock = serial_clock_reg;
    assign serial_load  = serial_load_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;

endmodule

// File: doc/pad_thru_cfg_sequencer.md
Name: pad_thru_cfg_sequencer

Overview:
Serial configuration sequencer for the openframe pad ring. It streams per-pad configuration words around the ring on the pass-through routing lines in the fill cells: thru0 carries serial data, thru1 carries the serial clock, and a separate load strobe latches the words. It sits in the core next to the pad configuration register file. It reads one word per pad, serialises the words MSB-first starting with the farthest pad, then issues a load strobe.

Parameters:
NUM_PADS, 44, number of pads in the chain (>=1)
CFG_BITS, 13, configuration bits per pad (>=1)
CLK_DIV, 4, system cycles per serial-clock phase (>=1)

Ports:
clock  input  1  system clock
reset  input  1  synchronous reset, active-high
start  input  1  request a full-chain load; sampled only in IDLE
cfg_addr  output  $clog2(NUM_PADS)  pad index whose word is being fetched
cfg_data  input  CFG_BITS  word for cfg_addr; combinational read, valid in the same cycle
serial_data  output  1  drives thru0
serial_clock  output  1  drives thru1; pads sample on its rising edge
serial_load  output  1  chain-wide latch strobe
busy  output  1  sequence in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset: one clock and one synchronous active-high reset. Clock port is clock, reset port is reset; polarity and synchronicity are fixed.
- Reset values, effective at the next clock edge: state=IDLE; cfg_addr=0; serial_data=0; serial_clock=0; serial_load=0; busy=0; done=0; all counters=0.
- Reset mid-sequence: abort immediately with the reset values above; no load pulse is issued; pad state is undefined until the next full sequence.
- States: IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD, DONE.
- IDLE: if start=1, go to FETCH with pad index = NUM_PADS-1 and busy=1 from the next cycle.
- FETCH (1 cycle): cfg_addr = pad index. Capture cfg_data into the shift register at the end of the cycle. Bit counter = CFG_BITS-1. Go to SHIFT_LO.
- SHIFT_LO (CLK_DIV cycles): serial_clock=0; serial_data = shift register bit [bit counter]. serial_data is stable for the whole bit (both phases). Go to SHIFT_HI.
- SHIFT_HI (CLK_DIV cycles): serial_clock=1; data unchanged. On exit:
  - bit counter>0: decrement it and go to SHIFT_LO.
  - bit counter=0 and pad index>0: decrement pad index and go to FETCH.
  - bit counter=0 and pad index=0: go to LOAD.
- LOAD (CLK_DIV cycles): serial_clock=0, serial_data=0, serial_load=1.
- DONE (1 cycle): done=1, busy=0, serial_load=0. Return to IDLE.
- Bit order: pad NUM_PADS-1 first, MSB first within each word. The last bit shifted is bit 0 of pad 0.
- Busy duration: NUM_PADS*(1 + 2*CLK_DIV*CFG_BITS) + CLK_DIV cycles. Start-to-done latency is that value plus 1.
- start while busy: ignored, no queuing. start held high through DONE: a new sequence begins from IDLE on the cycle after DONE.
- cfg_addr holds its last value outside FETCH.
- Counters use their exact widths; no wrap occurs because all decrements are guarded by the >0 checks above.

Optional Feature:
PAD_CFG_ABORT_EN

Defined:
- Adds input abort (1 bit).
- abort=1 in any state other than IDLE or DONE forces: serial_clock=0, serial_data=0, serial_load=0, busy=0, state=IDLE.
- done does not pulse on an abort; serial_load is never asserted after an abort.
- abort in IDLE has no effect.

Not defined:
- The abort port is absent; the block behaves exactly as described under Behaviour.

Test Plan:
1. Basic load. Setup: NUM_PADS=2, CFG_BITS=4, CLK_DIV=1; word[0]=4'hA, word[1]=4'h3; 1-cycle start pulse. Required: serial_data sampled on serial_clock rising edges = 0,0,1,1,1,0,1,0; cfg_addr=1 then 0 in the FETCH cycles; busy high for exactly 19 cycles; serial_load high for 1 cycle; done pulses once, the cycle after serial_load falls.
2. Divider. Setup: CLK_DIV=3, same words. Required: each serial_clock phase lasts 3 cycles; serial_load lasts 3 cycles; busy high for 2*(1+24)+3 = 53 cycles.
3. Start while busy. Required: start pulses at cycles 5 and 10 after the first start are ignored; exactly one done pulse, bit stream identical to scenario 1.
4. Reset mid-shift. Setup: assert reset for 1 cycle during the 5th bit. Required: all outputs 0 on the next edge; no serial_load pulse; a later start produces the full 8-bit stream from the beginning.
5. Edge sizes. Setup: NUM_PADS=1, CFG_BITS=1, CLK_DIV=1, word=1'b1. Required: one bit of 1, busy for 4 cycles, then done.
6. Abort (PAD_CFG_ABORT_EN defined). Setup: abort during the SHIFT_HI of the 3rd bit. Required: busy=0 and serial_clock=0 the next cycle; no serial_load and no done pulse; IDLE accepts a new start.
